// File: rtl/periph_system_pkg.sv
`default_nettype none
// periph_system_pkg -- shared constants, FSM encodings and helpers for periph_system (rev 1.0).
package periph_system_pkg;
  localparam logic [3:0] SPI_CMD_PREFIX  = 4'h5;
  localparam logic [7:0] ASCII_DIGIT_OFS = 8'h30;
  localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_SHIFT = 2'd1,
    SPI_GAP   = 2'd2
  } spi_state_t;

  function automatic int unsigned calc_bdiv(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? ASCII_DIGIT_OFS + {4'h0, nib} : ASCII_ALPHA_OFS + {4'h0, nib};
  endfunction
endpackage
`default_nettype wire

// File: rtl/periph_system_uart.sv
`default_nettype none
// uart_core -- 8N1 UART transmitter and receiver sharing one bit period of BDIV clocks (rev 1.0).
module uart_core
  import periph_system_pkg::*;
#(
  parameter int unsigned BDIV = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data
);
  localparam logic [15:0] BIT_LAST  = 16'(BDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BDIV / 2 - 1);

  uart_state_t tx_state, tx_state_nx, rx_state, rx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx, rx_cnt, rx_cnt_nx;
  logic [2:0]  tx_bit, tx_bit_nx, rx_bit, rx_bit_nx;
  logic [7:0]  tx_sh, tx_sh_nx, rx_sh, rx_sh_nx, rx_data_nx;
  logic        txd_nx, rxd_prev, rx_valid_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= UART_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
      rx_state <= UART_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rxd_prev <= 1'b1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_sh    <= tx_sh_nx;
      txd      <= txd_nx;
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_sh    <= rx_sh_nx;
      rxd_prev <= rxd;
      rx_valid <= rx_valid_nx;
      rx_data  <= rx_data_nx;
    end
  end

  assign tx_busy = (tx_state != UART_IDLE);

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + 16'd1;
    tx_bit_nx   = tx_bit;
    tx_sh_nx    = tx_sh;
    case (tx_state)
      UART_IDLE: begin
        tx_cnt_nx = '0;
        if (tx_start) begin
          tx_state_nx = UART_START;
          tx_sh_nx    = tx_data;
        end
      end
      UART_START: if (tx_cnt == BIT_LAST) begin
        tx_state_nx = UART_DATA;
        tx_cnt_nx   = '0;
        tx_bit_nx   = '0;
      end
      UART_DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_nx = '0;
        tx_sh_nx  = {1'b1, tx_sh[7:1]};
        tx_bit_nx = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_nx = UART_STOP;
      end
      default: if (tx_cnt == BIT_LAST) begin
        tx_state_nx = UART_IDLE;
        tx_cnt_nx   = '0;
      end
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (tx_state_nx)
      UART_START: txd_nx = 1'b0;
      UART_DATA:  txd_nx = tx_sh_nx[0];
      default:    txd_nx = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + 16'd1;
    rx_bit_nx   = rx_bit;
    rx_sh_nx    = rx_sh;
    rx_valid_nx = 1'b0;
    rx_data_nx  = rx_data;
    case (rx_state)
      UART_IDLE: begin
        rx_cnt_nx = '0;
        if (rxd_prev && !rxd) begin
          rx_state_nx = UART_START;
          rx_bit_nx   = '0;
        end
      end
      UART_START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_nx   = '0;
        rx_state_nx = rxd ? UART_IDLE : UART_DATA;
      end
      UART_DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_nx = '0;
        rx_sh_nx  = {rxd, rx_sh[7:1]};
        rx_bit_nx = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_nx = UART_STOP;
      end
      default: if (rx_cnt == BIT_LAST) begin
        rx_cnt_nx   = '0;
        rx_state_nx = UART_IDLE;
        rx_valid_nx = rxd;
        rx_data_nx  = rxd ? rx_sh : rx_data;
      end
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/periph_system.sv
`default_nettype none
// periph_system -- GPIO nibble changes go out as UART hex and SPI {5,N}; SPI reply or UART RX drives GPIO[7:4].
// Optional macro PERIPH_SYSTEM_UART_ECHO_EN echoes every accepted UART RX byte on TX (rev 1.0).
module periph_system
  import periph_system_pkg::*;
#(
  parameter int unsigned clk_freq       = 100000000,
  parameter int unsigned uart_baud_rate = 115200,
  parameter int unsigned spi_div        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic       uart_txd,
  input  logic       spi_miso,
  output logic       spi_mosi,
  output logic       spi_clk,
  output logic       spi_CE,
  inout  wire        i2c_sda,
  inout  wire        i2c_scl,
  inout  wire  [7:0] gpio0_io
);
  localparam int unsigned BDIV          = calc_bdiv(clk_freq, uart_baud_rate);
  localparam logic [15:0] SPI_HALF_LAST = 16'(spi_div - 1);

  logic [3:0] gpio_meta, gpio_sync, last_nib, gpio_out, spi_rx, spi_rx_nx;
  logic       rxd_meta, rxd_sync, miso_meta, miso_sync;
  logic       pending, dispatch, tx_start, tx_busy, rx_valid, spi_done;
  logic [7:0] tx_data, rx_data, spi_cmd, spi_tx, spi_tx_nx;
  spi_state_t spi_state, spi_state_nx;
  logic [15:0] spi_cnt, spi_cnt_nx;
  logic [2:0] spi_bit, spi_bit_nx;
  logic       sclk_nx, ce_nx, mosi_nx;

  assign gpio0_io = {gpio_out, 4'bzzzz};
  assign i2c_sda  = 1'bz;
  assign i2c_scl  = 1'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_meta <= '0;
      gpio_sync <= '0;
      rxd_meta  <= 1'b1;
      rxd_sync  <= 1'b1;
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      gpio_meta <= gpio0_io[3:0];
      gpio_sync <= gpio_meta;
      rxd_meta  <= uart_rxd;
      rxd_sync  <= rxd_meta;
      miso_meta <= spi_miso;
      miso_sync <= miso_meta;
    end
  end

`ifdef PERIPH_SYSTEM_UART_ECHO_EN
  logic       echo_pending, echo_go;
  logic [7:0] echo_byte;
  assign echo_go  = echo_pending && !tx_busy;
  assign dispatch = pending && !tx_busy && (spi_state == SPI_IDLE) && !echo_go;
  assign tx_start = echo_go || dispatch;
  assign tx_data  = echo_go ? echo_byte : hex_ascii(last_nib);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_pending <= 1'b0;
      echo_byte    <= '0;
    end else if (rx_valid) begin
      echo_pending <= 1'b1;
      echo_byte    <= rx_data;
    end else if (echo_go) begin
      echo_pending <= 1'b0;
    end
  end
`else
  logic unused_rx_hi;
  assign unused_rx_hi = ^rx_data[7:4];
  assign dispatch     = pending && !tx_busy && (spi_state == SPI_IDLE);
  assign tx_start     = dispatch;
  assign tx_data      = hex_ascii(last_nib);
`endif

  // A change seen in the dispatch cycle re-arms pending, so the latest nibble is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_nib <= '0;
      pending  <= 1'b0;
    end else begin
      if (dispatch) pending <= 1'b0;
      if (gpio_sync != last_nib) begin
        last_nib <= gpio_sync;
        pending  <= 1'b1;
      end
    end
  end

  uart_core #(.BDIV(BDIV)) u_uart (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .txd      (uart_txd),
    .rxd      (rxd_sync),
    .rx_valid (rx_valid),
    .rx_data  (rx_data)
  );

  assign spi_cmd = {SPI_CMD_PREFIX, last_nib};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spi_state <= SPI_IDLE;
      spi_cnt   <= '0;
      spi_bit   <= '0;
      spi_tx    <= '0;
      spi_rx    <= '0;
      spi_clk   <= 1'b0;
      spi_CE    <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      spi_state <= spi_state_nx;
      spi_cnt   <= spi_cnt_nx;
      spi_bit   <= spi_bit_nx;
      spi_tx    <= spi_tx_nx;
      spi_rx    <= spi_rx_nx;
      spi_clk   <= sclk_nx;
      spi_CE    <= ce_nx;
      spi_mosi  <= mosi_nx;
    end
  end

  // Only R[3:0] is consumed, so the receive shifter keeps just the last four bits.
  always_comb begin
    spi_state_nx = spi_state;
    spi_cnt_nx   = spi_cnt + 16'd1;
    spi_bit_nx   = spi_bit;
    spi_tx_nx    = spi_tx;
    spi_rx_nx    = spi_rx;
    sclk_nx      = spi_clk;
    ce_nx        = spi_CE;
    mosi_nx      = spi_mosi;
    spi_done     = 1'b0;
    case (spi_state)
      SPI_IDLE: begin
        spi_cnt_nx = '0;
        if (dispatch) begin
          spi_state_nx = SPI_SHIFT;
          spi_bit_nx   = '0;
          ce_nx        = 1'b0;
          mosi_nx      = spi_cmd[7];
          spi_tx_nx    = {spi_cmd[6:0], 1'b0};
        end
      end
      SPI_SHIFT: if (spi_cnt == SPI_HALF_LAST) begin
        spi_cnt_nx = '0;
        if (!spi_clk) begin
          sclk_nx   = 1'b1;
          spi_rx_nx = {spi_rx[2:0], miso_sync};
        end else begin
          sclk_nx = 1'b0;
          if (spi_bit == 3'd7) begin
            spi_state_nx = SPI_GAP;
            ce_nx        = 1'b1;
            mosi_nx      = 1'b0;
            spi_done     = 1'b1;
          end else begin
            mosi_nx    = spi_tx[7];
            spi_tx_nx  = {spi_tx[6:0], 1'b0};
            spi_bit_nx = spi_bit + 3'd1;
          end
        end
      end
      default: if (spi_cnt == SPI_HALF_LAST) begin
        spi_cnt_nx   = '0;
        spi_state_nx = SPI_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          gpio_out <= '0;
    else if (rx_valid) gpio_out <= rx_data[3:0];
    else if (spi_done) gpio_out <= spi_rx;
  end
endmodule
`default_nettype wire

// File: tb/tb_periph_system.sv
`default_nettype none
// tb_periph_system -- directed vectors for periph_system; monitors pop expected UART/SPI/GPIO results from queues.
module tb_periph_system;
  localparam int BIT_CLKS   = 86;
  localparam int SPI_PERIOD = 8;

  logic clk = 1'b0, rst = 1'b0, uart_rxd = 1'b1, spi_miso = 1'b0;
  logic [3:0] gpio_in = 4'h0;
  wire uart_txd, spi_mosi, spi_clk, spi_CE;
  wire i2c_sda, i2c_scl;
  wire [7:0] gpio0_io;

  assign gpio0_io[3:0] = gpio_in;
  pullup (i2c_sda);
  pullup (i2c_scl);

  int checks = 0, failures = 0;
  logic mon_en = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_mosi[$];
  logic [3:0] exp_gpio[$];

  always #5 clk = ~clk;

  periph_system #(
    .clk_freq       (100000000),
    .uart_baud_rate (1152000),
    .spi_div        (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd),
    .spi_miso (spi_miso),
    .spi_mosi (spi_mosi),
    .spi_clk  (spi_clk),
    .spi_CE   (spi_CE),
    .i2c_sda  (i2c_sda),
    .i2c_scl  (i2c_scl),
    .gpio0_io (gpio0_io)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_uart(input logic [7:0] data, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  initial begin : tx_monitor
    logic [7:0] got, exp;
    logic start_ok, stop_bit;
    forever begin
      @(negedge clk);
      if (mon_en && rst && uart_txd == 1'b0) begin
        repeat (BIT_CLKS / 2 - 1) @(negedge clk);
        start_ok = ~uart_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CLKS) @(negedge clk);
          got[i] = uart_txd;
        end
        repeat (BIT_CLKS) @(negedge clk);
        stop_bit = uart_txd;
        if (exp_tx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL uart_tx_unexpected: got 0x%02h with no frame expected", got);
        end else begin
          exp = exp_tx.pop_front();
          check("uart_tx_frame{start,stop,data}", {22'd0, start_ok, stop_bit, got}, {22'd0, 1'b1, 1'b1, exp});
        end
      end
    end
  end

  initial begin : spi_monitor
    logic [7:0] mosi_byte;
    logic prev_sclk;
    int pulses, since_rise, bad_period, guard;
    forever begin
      @(negedge clk);
      if (mon_en && rst && spi_CE == 1'b0) begin
        mosi_byte = '0; pulses = 0; since_rise = 0; bad_period = 0; guard = 0;
        prev_sclk = spi_clk;
        while (spi_CE == 1'b0 && guard < 200) begin
          if (spi_clk && !prev_sclk) begin
            if (pulses > 0 && since_rise != SPI_PERIOD) bad_period++;
            mosi_byte = {mosi_byte[6:0], spi_mosi};
            pulses++;
            since_rise = 0;
          end
          prev_sclk = spi_clk;
          since_rise++;
          guard++;
          @(negedge clk);
        end
        if (guard >= 200) begin
          checks++;
          failures++;
          $display("FAIL spi_timeout: spi_CE still low after %0d cycles, limit 200", guard);
        end
        check("spi_clk_pulses", pulses, 8);
        check("spi_clk_bad_periods", bad_period, 0);
        check("spi_clk_idle_low", {31'd0, spi_clk}, 0);
        check("spi_mosi_idle_low", {31'd0, spi_mosi}, 0);
        if (exp_mosi.size() == 0 || exp_gpio.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spi_unexpected: got mosi 0x%02h with no exchange expected", mosi_byte);
        end else begin
          check("spi_mosi_byte", mosi_byte, exp_mosi.pop_front());
          check("gpio_out_after_spi", gpio0_io[7:4], exp_gpio.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation exceeded 1 ms, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int zeros_tx, zeros_ce;
    logic found;
    #100;
    check("reset_uart_txd", {31'd0, uart_txd}, 1);
    check("reset_spi_CE", {31'd0, spi_CE}, 1);
    check("reset_spi_clk", {31'd0, spi_clk}, 0);
    check("reset_spi_mosi", {31'd0, spi_mosi}, 0);
    check("reset_gpio_out", gpio0_io[7:4], 4'h0);
    check("reset_i2c_sda_released", {31'd0, i2c_sda}, 1);
    check("reset_i2c_scl_released", {31'd0, i2c_scl}, 1);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    // Single event with MISO held high.
    spi_miso = 1'b1;
    exp_tx.push_back(8'h46); exp_mosi.push_back(8'h5F); exp_gpio.push_back(4'hF);
    gpio_in = 4'hF;
    repeat (1000) @(negedge clk);

    // MISO held low.
    spi_miso = 1'b0;
    exp_tx.push_back(8'h33); exp_mosi.push_back(8'h53); exp_gpio.push_back(4'h0);
    gpio_in = 4'h3;
    repeat (1000) @(negedge clk);

    // Back-to-back: 4 is superseded by C while '8' is still on the line.
    spi_miso = 1'b1;
    exp_tx.push_back(8'h38); exp_mosi.push_back(8'h58); exp_gpio.push_back(4'hF);
    gpio_in = 4'h8;
    repeat (100) @(negedge clk);
    gpio_in = 4'h4;
    repeat (50) @(negedge clk);
    gpio_in = 4'hC;
    repeat (150) @(negedge clk);
    spi_miso = 1'b0;
    exp_tx.push_back(8'h43); exp_mosi.push_back(8'h5C); exp_gpio.push_back(4'h0);
    repeat (1800) @(negedge clk);

    // UART RX: good frame, then framing error.
`ifdef PERIPH_SYSTEM_UART_ECHO_EN
    exp_tx.push_back(8'h3A);
`endif
    send_uart(8'h3A, 1'b1);
    repeat (10) @(negedge clk);
    check("rx_gpio_out", gpio0_io[7:4], 4'hA);
    send_uart(8'h37, 1'b0);
    repeat (20) @(negedge clk);
    check("rx_framing_error_gpio_out", gpio0_io[7:4], 4'hA);
    repeat (1000) @(negedge clk);

    // Mid-frame reset during data bit 1 of '5' (a zero bit).
    mon_en = 1'b0;
    spi_miso = 1'b1;
    gpio_in = 4'h5;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (!uart_txd) found = 1'b1;
    end
    check("reset_test_frame_start", {31'd0, found}, 1);
    repeat (2 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    check("tx_bit1_before_reset", {31'd0, uart_txd}, 0);
    check("gpio_before_reset", gpio0_io[7:4], 4'hF);
    rst = 1'b0;
    #1;
    check("midreset_uart_txd", {31'd0, uart_txd}, 1);
    check("midreset_spi_CE", {31'd0, spi_CE}, 1);
    check("midreset_gpio_out", gpio0_io[7:4], 4'h0);
    gpio_in = 4'h0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    zeros_tx = 0;
    zeros_ce = 0;
    repeat (1200) begin
      @(negedge clk);
      if (!uart_txd) zeros_tx++;
      if (!spi_CE) zeros_ce++;
    end
    check("after_reset_txd_low_cycles", zeros_tx, 0);
    check("after_reset_CE_low_cycles", zeros_ce, 0);

    check("exp_tx_left", exp_tx.size(), 0);
    check("exp_mosi_left", exp_mosi.size(), 0);
    check("exp_gpio_left", exp_gpio.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/periph_system.md
Name: periph_system

Overview:
- Self-contained peripheral subsystem. It links an 8-bit split GPIO port, an 8N1 UART, a mode-0 SPI master and an idle I2C port.
- A change on the GPIO input nibble is reported as an ASCII hex character on UART TX. It also starts one SPI byte exchange.
- The SPI reply byte, or a byte received on UART RX, sets the GPIO output nibble.
- Sits at the top of the FPGA design, directly on board pins.

Parameters:
- clk_freq, 100000000, system clock frequency in Hz.
- uart_baud_rate, 115200, UART bit rate. Bit period BDIV = clk_freq/uart_baud_rate clocks, truncating division.
- spi_div, 4, clocks per SPI half-period. spi_clk frequency = clk_freq/(2*spi_div).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- uart_rxd  in  1  UART receive, idle high, asynchronous to clk.
- uart_txd  out  1  UART transmit, idle high.
- spi_miso  in  1  SPI master-in data.
- spi_mosi  out  1  SPI master-out data.
- spi_clk  out  1  SPI clock, idle low.
- spi_CE  out  1  SPI chip enable, active low.
- i2c_sda  inout  1  I2C data, open drain.
- i2c_scl  inout  1  I2C clock, open drain.
- gpio0_io  inout  8  bits[3:0] are inputs (never driven). Bits[7:4] are outputs, always driven.

Behaviour:
- Reset (rst=0, asynchronous), outputs:
  - uart_txd=1, spi_CE=1, spi_clk=0, spi_mosi=0.
  - gpio0_io[7:4]=0.
  - i2c_sda and i2c_scl high-Z.
- Reset, internal state: all FSMs idle, pending flag clear, last-accepted nibble=0.
- Input synchronisers: gpio0_io[3:0], uart_rxd and spi_miso each pass through a 2-FF synchroniser before use.
- GPIO event:
  - Synced nibble S is compared each cycle with last-accepted nibble L.
  - When S≠L: L<=S and pending<=1. If pending was already set, only L updates (latest value wins, single-depth).
- Dispatch:
  - Condition: pending=1 and both UART TX and SPI are idle.
  - Clear pending. Latch N=L.
  - Start UART TX of ASCII hex(N): 0x30+N for N<10, 0x37+N otherwise.
  - Start SPI exchange of byte {4'h5,N} in the same cycle.
- UART TX:
  - 8N1, LSB first. Start bit, 8 data bits, 1 stop bit, each BDIV clocks.
  - The start bit begins the cycle after dispatch. Busy until the stop bit ends.
- UART RX:
  - Falling edge on synced rxd starts reception. Rxd is re-checked at BDIV/2; if high, it is a false start and RX returns to idle.
  - Data bits are sampled at bit centres. The stop bit is sampled at its centre.
  - Stop bit=1: byte accepted, gpio0_io[7:4]<=byte[3:0] next cycle.
  - Stop bit=0 (framing error): byte discarded, outputs unchanged.
- SPI master (mode 0, MSB first):
  - Dispatch cycle+1: spi_CE=0, spi_mosi=bit7.
  - Each half-period is spi_div clocks. spi_clk rises: synced miso is shifted in. spi_clk falls: next MOSI bit is presented.
  - After the 8th falling edge, spi_CE=1 and spi_mosi=0. Received byte R is complete.
  - gpio0_io[7:4]<=R[3:0] in that cycle.
  - spi_CE must stay high at least one half-period before the next exchange.
- Output conflict: if an RX-accepted byte and SPI completion update gpio0_io[7:4] in the same cycle, UART RX wins.
- I2C: both lines permanently released (high-Z). Incoming values are ignored.
- Reset asserted mid-operation: immediate return to reset values, and the current frame or exchange is aborted.

Optional Feature:
- Macro: PERIPH_SYSTEM_UART_ECHO_EN.
- Defined:
  - Every byte accepted by UART RX is also queued for retransmission on TX in a 1-byte echo buffer.
  - Echo has priority over GPIO dispatch when TX is idle. A new RX byte overwrites an unsent echo.
- Undefined: TX carries only GPIO hex characters. No echo logic is present.

Decomposition:
- Package periph_system_pkg holds:
  - SPI command prefix 4'h5.
  - ASCII offsets 0x30 and 0x37.
  - UART FSM state enum: IDLE, START, DATA, STOP.
  - SPI FSM state enum: IDLE, SHIFT, GAP.
  - A function computing BDIV.
- Sub-module uart_core: TX and RX with a baud counter, instantiated once.
- The SPI master and GPIO logic stay inline in the top.

Test Plan:
- Reset check: rst=0 for 100 ns → uart_txd=1, spi_CE=1, spi_clk=0, gpio0_io[7:4]=0, i2c lines high-Z.
- Single GPIO event. Setup: clk 10 ns, clk_freq=100000000, uart_baud_rate=1152000 (BDIV=86), drive gpio0_io[3:0]=4'hF.
  - UART frame 0x46 ('F') with 860 ns bits.
  - MOSI byte 0x5F, 8 spi_clk pulses at 80 ns period.
- MISO capture: hold spi_miso=1 through an exchange → gpio0_io[7:4]=4'hF. Hold spi_miso=0 → 4'h0.
- Back-to-back events: drive 4'h8, then 4'h4 and 4'hC while TX is busy. Expected transmissions: '8' then 'C' only; MOSI 0x58 then 0x5C.
- UART RX: send 0x3A at 1152000 baud → gpio0_io[7:4]=4'hA. Send 0x37 with stop bit 0 → output unchanged.
- Mid-frame reset: pulse rst low during a TX data bit → uart_txd=1 immediately. No further bits of that frame follow after release.
